// File: rtl/mem_b.sv
// rtl/mem_b.sv - skewed per-lane shift-register FIFOs feeding the systolic array B columns
module mem_b #(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic signed [BITS_AB-1:0] Bin  [DIM-1:0],
   output logic signed [BITS_AB-1:0] Bout [DIM-1:0]
);

   // Lane i is DIM+i deep, so column i sees its operands i cycles after column 0.
   for (genvar i = 0; i < DIM; i++) begin : g_lane
      localparam int DEPTH = DIM + i;

      logic signed [BITS_AB-1:0] stage [DEPTH-1:0];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
               stage[k] <= '0;
            end
         end else if (en) begin
            stage[0] <= Bin[i];
            for (int k = 1; k < DEPTH; k++) begin
               stage[k] <= stage[k-1];
            end
         end
      end

      assign Bout[i] = stage[DEPTH-1];
   end

endmodule

// File: tb/tb_mem_b.sv
// tb/tb_mem_b.sv - self-checking bench for mem_b using an input-history scoreboard
module tb_mem_b;

   localparam int BITS = 8;
   localparam int DIM  = 8;

   typedef logic [DIM*BITS-1:0] vec_t;

   logic                   clk;
   logic                   rst_n;
   logic                   en;
   logic signed [BITS-1:0] bin  [DIM-1:0];
   logic signed [BITS-1:0] bout [DIM-1:0];

   int   checks;
   int   errors;
   int   edges;
   vec_t hist [$];
   vec_t expq [$];

   mem_b #(.BITS_AB(BITS), .DIM(DIM)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .Bin  (bin),
      .Bout (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic logic signed [BITS-1:0] lane_of(input vec_t v, input int i);
      return v[i*BITS +: BITS];
   endfunction

   // Lane i shows the input of enabled edge n-(DIM+i-1); before that it is still 0.
   function automatic vec_t expected();
      vec_t e;
      int   idx;
      e = '0;
      for (int i = 0; i < DIM; i++) begin
         idx = hist.size() - DIM - i;
         if (idx >= 0) e[i*BITS +: BITS] = lane_of(hist[idx], i);
      end
      return e;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v;
      for (int i = 0; i < DIM; i++) v[i*BITS +: BITS] = BITS'($urandom);
      return v;
   endfunction

   function automatic vec_t fill_vec(input logic [BITS-1:0] b);
      vec_t v;
      for (int i = 0; i < DIM; i++) v[i*BITS +: BITS] = b;
      return v;
   endfunction

   task automatic check_zero(input string tag);
      for (int i = 0; i < DIM; i++) check($sformatf("%s_lane%0d", tag, i), int'(bout[i]), 0);
   endtask

   // Called at a falling edge; drives one cycle and compares against the scoreboard.
   task automatic step(input logic en_v, input vec_t v, input logic xin);
      vec_t e;
      en = en_v;
      for (int i = 0; i < DIM; i++) bin[i] = xin ? 'x : lane_of(v, i);
      if (en_v) begin
         hist.push_back(v);
         edges++;
      end
      expq.push_back(expected());
      @(posedge clk);
      #2;
      e = expq.pop_front();
      for (int i = 0; i < DIM; i++)
         check($sformatf("sb_e%0d_lane%0d", edges, i), int'(bout[i]), int'(lane_of(e, i)));
      @(negedge clk);
   endtask

   task automatic do_reset();
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      hist.delete();
      expq.delete();
      edges = 0;
   endtask

   initial begin
      vec_t v;
      logic [BITS-1:0] n;
      checks = 0;
      errors = 0;
      edges  = 0;
      rst_n  = 1'b0;
      en     = 1'b0;
      for (int i = 0; i < DIM; i++) bin[i] = '0;

      // Reset held with en=1 and random data: outputs stay 0
      #1;
      check_zero("rst_init");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         en = 1'b1;
         for (int i = 0; i < DIM; i++) bin[i] = BITS'($urandom);
         @(posedge clk);
         #2;
         check_zero($sformatf("rst_hold%0d", c));
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, rand_vec(), 1'b0);
      check_zero("rst_release");

      // Diagonal skew
      do_reset();
      for (int i = 0; i < DIM; i++) v[i*BITS +: BITS] = BITS'(i + 1);
      step(1'b1, v, 1'b0);
      for (int k = 2; k <= 2*DIM; k++) begin
         step(1'b1, '0, 1'b0);
         if (edges == DIM)         check("skew_lane0", int'(bout[0]), 1);
         if (edges == DIM + 1)     check("skew_lane0_gone", int'(bout[0]), 0);
         if (edges == 2*DIM - 1)   check("skew_lane7", int'(bout[DIM-1]), DIM);
         if (edges == 2*DIM)       check("skew_lane7_gone", int'(bout[DIM-1]), 0);
      end

      // Hold across stalls with undriven input
      do_reset();
      step(1'b1, fill_vec(8'hFB), 1'b0);
      for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1);
      for (int k = 1; k <= DIM + 8; k++) begin
         step(1'b1, '0, 1'b0);
         if (k == DIM - 1) check("hold_lane0", int'(bout[0]), -5);
         if (k == DIM)     check("hold_lane0_once", int'(bout[0]), 0);
      end

      // Streaming through the signed wrap point
      do_reset();
      n = 8'd100;
      for (int k = 0; k < 40; k++) begin
         step(1'b1, fill_vec(n), 1'b0);
         n = n + 8'd1;
      end

      // Mixed random stream with stalls
      for (int k = 0; k < 40; k++) step(1'($urandom_range(0, 1)), rand_vec(), 1'b0);

      // Asynchronous reset between edges while lanes hold data
      rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      hist.delete();
      expq.delete();
      edges = 0;
      @(posedge clk);
      #2;
      check_zero("async_rst_edge");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 2*DIM + 2; k++) step(1'b1, rand_vec(), 1'b0);

      // Lane independence
      do_reset();
      v = '0;
      v[3*BITS +: BITS] = 8'h7F;
      step(1'b1, v, 1'b0);
      for (int k = 2; k <= 2*DIM + 2; k++) begin
         step(1'b1, '0, 1'b0);
         if (edges == DIM + 3) check("indep_lane3", int'(bout[3]), 127);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_b.md
MEM_B -- requirements
Module: mem_b

Interface
REQ-001 Parameter BITS_AB, default 8, width in bits of each signed B element.
REQ-002 Parameter DIM, default 8, number of lanes (systolic-array columns); minimum 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  shift enable; 1 = all lanes advance one stage this edge, 0 = hold.
REQ-006 Bin  input  DIM x BITS_AB signed, unpacked array [DIM-1:0]  new element per lane, sampled when en=1.
REQ-007 Bout  output  DIM x BITS_AB signed, unpacked array [DIM-1:0]  oldest element of each lane.

Function
REQ-008 Block SHALL contain DIM independent shift-register FIFOs; lane i SHALL hold exactly DIM+i stages of BITS_AB bits (lane 0: DIM stages, lane DIM-1: 2*DIM-1 stages), producing the diagonal skew the systolic array needs.
REQ-009 On a rising clk edge with en=1 and rst_n=1, each lane i SHALL load Bin[i] into stage 0 and move stage k-1 into stage k for every k>=1; the content of the last stage is discarded.
REQ-010 On a rising clk edge with en=0, all stages in all lanes SHALL hold their values.
REQ-011 Bout[i] SHALL be driven combinationally from the last stage (stage DIM+i-1) of lane i; no extra output register.
REQ-012 Latency: a value sampled on Bin[i] at enabled edge n SHALL appear on Bout[i] immediately after enabled edge n+DIM+i-1 and remain until the next enabled edge; only enabled edges count.
REQ-013 Data SHALL pass unmodified, signed, full BITS_AB width; no arithmetic, saturation or sign change.
REQ-014 Lanes SHALL be mutually independent except for the shared en; Bin[j] never affects Bout[i] for i!=j.
REQ-015 No full/empty flags: the FIFOs are always full by construction; every enabled edge is simultaneously one push and one pop per lane.
REQ-016 X/undriven Bin while en=0 SHALL NOT affect state.

Reset
REQ-017 While rst_n=0, every stage of every lane SHALL clear to 0 immediately (asynchronously), so all Bout[i]=0, independent of clk and en.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight data; after release, Bout[i] SHALL stay 0 until DIM+i enabled edges have shifted new data through.
REQ-019 First enabled edge after rst_n rises SHALL behave as a normal shift per REQ-009.

Verification
REQ-020 Reset: drive rst_n=0 with en=1 and Bin random for 3 cycles -> all Bout[i]=0 throughout; release -> Bout still 0 on next edge.
REQ-021 Skew: after reset, DIM=8, apply Bin[i]=i+1 on one enabled edge then Bin=0 with en=1 -> Bout[0]=1 after the 8th enabled edge, Bout[7]=8 after the 15th, each visible exactly one cycle.
REQ-022 Hold: load Bin[i]=-5 (0xFB) on one enabled edge, then en=0 for 10 cycles, then en=1 -> Bout[0]=-5 after 7 further enabled edges, counted excluding stalled cycles; no values lost or duplicated.
REQ-023 Streaming: en=1 continuously, Bin[i]=cycle count n -> Bout[i]=n-(DIM+i-1) once pipeline is filled, signed values -128 and 127 pass unchanged.
REQ-024 Async reset mid-stream: assert rst_n=0 between clock edges while lanes hold nonzero data -> all Bout[i]=0 before the next clk edge; subsequent refill per REQ-018.
REQ-025 Independence: drive only Bin[3]=0x7F, others 0, for one enabled edge -> only Bout[3] ever becomes nonzero (after 11 enabled edges).
